// File: rtl/fp_share_arbiter.sv
// fp_share_arbiter
//   Shares one FP unit between NREQ requesters. A round-robin arbiter picks a
//   requester, captures its operands, pulses startFP, waits for doneFP,
//   registers the result and hands it back over a resultReady/resultAccepted
//   handshake.
//
// Optional feature: define FP_TIMEOUT_EN to abandon WAIT after TIMEOUT_CYC
//   cycles without doneFP (result forced to qNaN, timeout_o pulses).
//
// Ports
//   clk_i, rst_i         clock (posedge), synchronous active-high reset
//   req_i[i]             requester i has valid operands
//   opA_i/opB_i[i]       operands of requester i
//   grant_o              one-hot, 1-cycle pulse, operands captured that cycle
//   startFP_o            1-cycle start pulse to the FP unit
//   inA_o/inB_o          registered operands to the FP unit
//   doneFP_i, result_i   FP unit completion and result (looked at only in WAIT)
//   resultReady_o[i]     result offered to owner i
//   resultAccepted_i[i]  acknowledge from requester i (level)
//   outBus_o             registered result, held until the next capture
//   busy_o               high in every state except IDLE
//   timeout_o            1-cycle pulse when WAIT is abandoned (0 without macro)
module fp_share_arbiter #(
  parameter int NREQ        = 4,
  parameter int W           = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ-1:0][W-1:0]   opA_i,
  input  logic [NREQ-1:0][W-1:0]   opB_i,
  output logic [NREQ-1:0]          grant_o,
  output logic                     startFP_o,
  output logic [W-1:0]             inA_o,
  output logic [W-1:0]             inB_o,
  input  logic                     doneFP_i,
  input  logic [W-1:0]             result_i,
  output logic [NREQ-1:0]          resultReady_o,
  input  logic [NREQ-1:0]          resultAccepted_i,
  output logic [W-1:0]             outBus_o,
  output logic                     busy_o,
  output logic                     timeout_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_CAPTURE, S_DELIVER, S_RELEASE
  } state_e;

  state_e          state_q;
  logic [PW-1:0]   rr_ptr_q;
  logic [PW-1:0]   owner_q;
  logic [W-1:0]    inA_q, inB_q, outBus_q;

  logic [PW-1:0]   win_d;
  logic            found;
  int              idx;
  logic [PW-1:0]   owner_nxt;
  logic [NREQ-1:0] owner_oh;
  logic            own_acc;

`ifdef FP_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [W-1:0] QNAN = W'(32'h7FC0_0000);
  logic [CW-1:0]   wcnt_q;
  logic            timeout_q;
`endif

  // Round-robin pick: scan from rr_ptr upward with wrap; first set req wins.
  always_comb begin
    win_d = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!found && req_i[idx]) begin
        found = 1'b1;
        win_d = PW'(idx);
      end
    end
  end

  // Explicit wrap so non-power-of-2 NREQ stays in range.
  assign owner_nxt = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
  assign owner_oh  = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
  assign own_acc   = resultAccepted_i[owner_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      inA_q    <= '0;
      inB_q    <= '0;
      outBus_q <= '0;
`ifdef FP_TIMEOUT_EN
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef FP_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: if (|req_i) begin
          owner_q <= win_d;
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          inA_q   <= opA_i[owner_q];
          inB_q   <= opB_i[owner_q];
          state_q <= S_START;
        end
        S_START: begin
          // doneFP in this cycle belongs to no operation yet and is dropped.
`ifdef FP_TIMEOUT_EN
          wcnt_q <= '0;
`endif
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // doneFP has priority over the timeout on the final cycle.
          if (doneFP_i) begin
            outBus_q <= result_i;
            state_q  <= S_CAPTURE;
          end
`ifdef FP_TIMEOUT_EN
          else if (wcnt_q == CW'(TIMEOUT_CYC - 1)) begin
            outBus_q  <= QNAN;
            timeout_q <= 1'b1;
            state_q   <= S_CAPTURE;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
`endif
        end
        S_CAPTURE: state_q <= S_DELIVER;
        S_DELIVER: if (own_acc) state_q <= S_RELEASE;
        S_RELEASE: if (!own_acc) begin
          // Only place the pointer moves, so fairness follows completed service.
          rr_ptr_q <= owner_nxt;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant_o       = (state_q == S_LOAD)    ? owner_oh : '0;
  assign resultReady_o = (state_q == S_DELIVER) ? owner_oh : '0;
  assign startFP_o     = (state_q == S_START);
  assign busy_o        = (state_q != S_IDLE);
  assign inA_o         = inA_q;
  assign inB_o         = inB_q;
  assign outBus_o      = outBus_q;

`ifdef FP_TIMEOUT_EN
  assign timeout_o = timeout_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYC != 0);
  assign timeout_o      = 1'b0;
`endif

endmodule

// File: tb/tb_fp_share_arbiter.sv
module tb_fp_share_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 32;
`ifdef FP_TIMEOUT_EN
  localparam int TMO    = 10;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO    = 255;
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0] req = '0, acc = '0;
  logic [NREQ-1:0][W-1:0] opA = '0, opB = '0;
  logic doneFP = 1'b0;
  logic [W-1:0] result = '0;
  logic [NREQ-1:0] grant, rr;
  logic startFP, busy, tmo;
  logic [W-1:0] inA, inB, outBus;

  fp_share_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT_CYC(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .opA_i(opA), .opB_i(opB),
    .grant_o(grant), .startFP_o(startFP), .inA_o(inA), .inB_o(inB),
    .doneFP_i(doneFP), .result_i(result), .resultReady_o(rr),
    .resultAccepted_i(acc), .outBus_o(outBus), .busy_o(busy), .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Walks one transaction as a story: pick winner, load, start, wait for the
  // unit, offer result, wait for accept then release. Expectations describe
  // the cycle following each posedge.
  logic [NREQ-1:0] e_grant = '0, e_rr = '0;
  logic e_start = 1'b0, e_busy = 1'b0, e_tmo = 1'b0;
  logic [W-1:0] e_inA = '0, e_inB = '0, e_out = '0;
  int m_ptr = 0;

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  task automatic mreset();
    m_ptr = 0; e_inA = '0; e_inB = '0; e_out = '0;
    e_grant = '0; e_rr = '0; e_start = 1'b0; e_busy = 1'b0; e_tmo = 1'b0;
  endtask

  task automatic run_txn(output bit ab);
    int own, waited;
    ab = 1'b0;
    own = pick(req, m_ptr);
    e_busy = 1'b1; e_grant = '0; e_grant[own] = 1'b1;
    @(posedge clk); if (rst) begin ab = 1'b1; return; end
    e_inA = opA[own]; e_inB = opB[own]; e_grant = '0; e_start = 1'b1;
    @(posedge clk); if (rst) begin ab = 1'b1; return; end
    e_start = 1'b0; waited = 0;
    forever begin
      @(posedge clk); if (rst) begin ab = 1'b1; return; end
      waited++;
      if (doneFP) begin e_out = result; break; end
      if (TMO_EN && waited == TMO) begin e_out = 32'h7FC0_0000; e_tmo = 1'b1; break; end
    end
    @(posedge clk); if (rst) begin ab = 1'b1; return; end
    e_tmo = 1'b0; e_rr[own] = 1'b1;
    do begin @(posedge clk); if (rst) begin ab = 1'b1; return; end end while (!acc[own]);
    e_rr = '0;
    do begin @(posedge clk); if (rst) begin ab = 1'b1; return; end end while (acc[own]);
    m_ptr = (own + 1) % NREQ; e_busy = 1'b0;
  endtask

  initial begin : model
    bit ab;
    mreset();
    forever begin
      @(posedge clk);
      if (rst) begin mreset(); continue; end
      if (req != '0) begin run_txn(ab); if (ab) mreset(); end
    end
  end

  always @(negedge clk) if (chk_on) begin
    chk("grant", 64'(grant), 64'(e_grant));
    chk("startFP", 64'(startFP), 64'(e_start));
    chk("inA", 64'(inA), 64'(e_inA));
    chk("inB", 64'(inB), 64'(e_inB));
    chk("resultReady", 64'(rr), 64'(e_rr));
    chk("outBus", 64'(outBus), 64'(e_out));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("timeout", 64'(tmo), 64'(e_tmo));
  end

  // ---------------- stimulus ----------------
  bit auto_fp = 1'b0, auto_acc = 1'b0, rnd = 1'b0;
  int fp_cnt = 0;

  task automatic tick();
    @(posedge clk); #1;
    if (auto_fp) begin
      doneFP = 1'b0;
      if (startFP) fp_cnt = $urandom_range(1, 4);
      else if (fp_cnt > 0) begin
        fp_cnt--;
        if (fp_cnt == 0) begin doneFP = 1'b1; result = $urandom; end
      end
    end
    if (auto_acc) acc = rr;
    if (rnd) begin
      rst = ($urandom_range(0, 199) == 0);
      req = ($urandom_range(0, 2) == 0) ? NREQ'($urandom) : '0;
      for (int i = 0; i < NREQ; i++) begin opA[i] = $urandom; opB[i] = $urandom; end
      doneFP = ($urandom_range(0, 4) == 0);
      result = $urandom;
      acc    = NREQ'($urandom);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 200) begin tick(); n++; end
    chk(nm, 64'(n < 200), 64'(1));
  endtask

  task automatic wait_grant(input string nm, output int gi);
    int n = 0;
    while (grant == '0 && n < 60) begin tick(); n++; end
    chk(nm, 64'(n < 60), 64'(1));
    gi = 0;
    for (int i = 0; i < NREQ; i++) if (grant[i]) gi = i;
  endtask

  initial begin
    int gi;
    int order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    // Reset state
    tick(); chk_on = 1'b1; tick(); rst = 1'b0;
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_outBus", 64'(outBus), 64'(0));
    chk("rst_inA", 64'(inA), 64'(0));

    // 1. Single requester with literal latencies
    req = 4'b0010; opA[1] = 32'd20; opB[1] = 32'd3;
    tick(); chk("t1_grant", 64'(grant), 64'h2); req = '0;
    tick(); chk("t1_start", 64'(startFP), 64'(1));
    chk("t1_inA", 64'(inA), 64'd20); chk("t1_inB", 64'(inB), 64'd3);
    repeat (4) tick();
    doneFP = 1'b1; result = 32'h41B8_0000;
    tick(); doneFP = 1'b0; result = '0;
    chk("t1_rr_capture", 64'(rr), 64'(0));
    tick(); chk("t1_rr", 64'(rr), 64'h2); chk("t1_out", 64'(outBus), 64'h41B8_0000);
    acc = 4'b0010;
    tick(); chk("t1_rr_release", 64'(rr), 64'(0)); chk("t1_busy_rel", 64'(busy), 64'(1));
    acc = '0;
    tick(); chk("t1_idle", 64'(busy), 64'(0));

    // 2. Fairness with all requesters held
    do_reset();
    for (int i = 0; i < NREQ; i++) opA[i] = $urandom;
    req = '1; auto_fp = 1'b1; auto_acc = 1'b1;
    for (int n = 0; n < 8; n++) begin
      wait_grant("t2_wait_grant", gi);
      chk("t2_order", 64'(gi), 64'(order[n]));
      tick(); chk("t2_inA", 64'(inA), 64'(opA[gi]));
    end
    req = '0; wait_idle("t2_idle");

    // 3/4. Handshake hold, non-owner accept, spurious doneFP, result change
    auto_fp = 1'b0; auto_acc = 1'b0; do_reset();
    req = 4'b0001;
    tick(); chk("t3_grant", 64'(grant), 64'h1); req = '0;
    tick(); chk("t3_start", 64'(startFP), 64'(1));
    doneFP = 1'b1; result = 32'hDEAD_BEEF;
    tick(); doneFP = 1'b0; chk("t3_wait_busy", 64'(busy), 64'(1));
    tick(); doneFP = 1'b1; result = 32'h3F80_0000;
    tick(); doneFP = 1'b0;
    tick(); chk("t3_rr", 64'(rr), 64'h1);
    acc = 4'b1110; doneFP = 1'b1; result = 32'h1234_5678;
    repeat (3) begin
      tick(); chk("t3_nonowner_rr", 64'(rr), 64'h1);
      chk("t3_hold_out", 64'(outBus), 64'h3F80_0000);
    end
    acc = 4'b0001; doneFP = 1'b0; req = '1;
    for (int n = 0; n < 20; n++) begin
      tick(); chk("t3_rr_drop", 64'(rr), 64'(0));
      chk("t3_no_grant", 64'(grant), 64'(0));
      chk("t3_out_held", 64'(outBus), 64'h3F80_0000);
    end
    acc = '0;
    tick(); chk("t3_idle", 64'(busy), 64'(0));
    tick(); chk("t3_next_grant", 64'(grant), 64'h2);
    req = '0; auto_fp = 1'b1; auto_acc = 1'b1; wait_idle("t3_done");

    // 5. Reset while in WAIT
    auto_fp = 1'b0; auto_acc = 1'b0;
    req = 4'b0100; tick(); req = '0; tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_grant", 64'(grant), 64'(0)); chk("t5_start", 64'(startFP), 64'(0));
    chk("t5_busy", 64'(busy), 64'(0)); chk("t5_out", 64'(outBus), 64'(0));
    chk("t5_inA", 64'(inA), 64'(0)); chk("t5_rr", 64'(rr), 64'(0));
    doneFP = 1'b1; tick(); doneFP = 1'b0;
    chk("t5_done_ignored", 64'(busy), 64'(0)); chk("t5_no_rr", 64'(rr), 64'(0));
    req = '1; tick(); chk("t5_ptr0", 64'(grant), 64'h1);
    req = '0; auto_fp = 1'b1; auto_acc = 1'b1; wait_idle("t5_done");

    // 6. FP unit never answers
    auto_fp = 1'b0; auto_acc = 1'b0;
    req = 4'b0010; tick(); req = '0; tick();
`ifdef FP_TIMEOUT_EN
    repeat (10) begin tick(); chk("t6_no_tmo_yet", 64'(tmo), 64'(0)); end
    tick(); chk("t6_tmo", 64'(tmo), 64'(1)); chk("t6_qnan", 64'(outBus), 64'h7FC0_0000);
    tick(); chk("t6_tmo_pulse", 64'(tmo), 64'(0)); chk("t6_rr", 64'(rr), 64'h2);
`else
    repeat (1000) tick();
    chk("t6_busy", 64'(busy), 64'(1)); chk("t6_no_rr", 64'(rr), 64'(0));
    chk("t6_tmo", 64'(tmo), 64'(0));
    doneFP = 1'b1; tick(); doneFP = 1'b0;
`endif
    auto_acc = 1'b1; wait_idle("t6_done"); auto_acc = 1'b0;

    // Random traffic against the model
    rnd = 1'b1;
    repeat (4000) tick();
    rnd = 1'b0; req = '0; acc = '0; doneFP = 1'b0;
    do_reset(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
